// File: rtl/br_enc_priority_encoder_pkg.sv
// +--------------------------------------------------------------------+
// | br_enc_priority_encoder_pkg: configuration legality helpers.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package br_enc_priority_encoder_pkg;

  localparam int c_MIN_REQUESTERS = 2;
  localparam int c_MIN_RESULTS    = 1;

  function automatic bit legal_requesters(input int nreq);
    return nreq >= c_MIN_REQUESTERS;
  endfunction

  function automatic bit legal_results(input int nreq, input int nres);
    return (nres >= c_MIN_RESULTS) && (nres <= nreq);
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_enc_find_first_set.sv
// +--------------------------------------------------------------------+
// | br_enc_find_first_set: one-hot of the lowest set bit of in.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module br_enc_find_first_set #(
  parameter int Width = 2
) (
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out
);

  // A bit survives only if no lower-index bit is set.
  logic [Width-1:0] w_lower_or;

  always_comb begin
    w_lower_or    = '0;
    w_lower_or[0] = 1'b0;
    for (int i = 1; i < Width; i++) begin
      w_lower_or[i] = w_lower_or[i-1] | in[i-1];
    end
  end

  assign out = in & ~w_lower_or;

endmodule

`default_nettype wire

// File: rtl/br_enc_priority_encoder.sv
// +--------------------------------------------------------------------+
// | br_enc_priority_encoder: find the first NumResults set bits of in. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module br_enc_priority_encoder
  import br_enc_priority_encoder_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int NumResults    = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NumRequesters-1:0]                 in,
  output logic [NumResults-1:0][NumRequesters-1:0] out
);

  if (!legal_requesters(NumRequesters)) begin : g_bad_requesters
    $error("NumRequesters must be >= 2");
  end
  if (!legal_results(NumRequesters, NumResults)) begin : g_bad_results
    $error("NumResults must be in 1..NumRequesters");
  end

  logic [NumResults-1:0][NumRequesters-1:0] w_mask;

  assign w_mask[0] = in;

  for (genvar k = 0; k < NumResults; k++) begin : g_result
    br_enc_find_first_set #(
      .Width (NumRequesters)
    ) u_ffs (
      .in  (w_mask[k]),
      .out (out[k])
    );
    if (k < NumResults - 1) begin : g_chain
      assign w_mask[k+1] = w_mask[k] & ~out[k];
    end
  end

  // Checks only; the datapath itself carries no state.
  always @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown(in)) else $error("in has X/Z");
      for (int k = 0; k < NumResults; k++) begin
        assert ($onehot0(out[k])) else $error("out[%0d] not onehot0", k);
        assert ((out[k] & ~in) == '0) else $error("out[%0d] not subset of in", k);
        for (int j = 0; j < k; j++) begin
          assert ((out[j] & out[k]) == '0) else $error("out[%0d]/out[%0d] overlap", j, k);
        end
        if (k > 0) begin
          assert ((out[k] == '0) || (out[k-1] != '0))
            else $error("out[%0d] set with out[%0d] empty", k, k - 1);
          assert ((out[k] == '0) || (out[k-1] == '0) || (out[k] > out[k-1]))
            else $error("out[%0d] index not above out[%0d]", k, k - 1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_br_enc_priority_encoder.sv
// +--------------------------------------------------------------------+
// | tb_br_enc_priority_encoder: directed checks over four configs.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_br_enc_priority_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic [3:0]  in_c = '0;
  logic [7:0]  in_d = '0;
  logic [0:0][1:0] out_a;
  logic [1:0][3:0] out_b;
  logic [3:0][3:0] out_c;
  logic [2:0][7:0] out_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  br_enc_priority_encoder #(.NumRequesters(2), .NumResults(1)) u_dut_a (
    .clk(clk), .rst(rst_n), .in(in_a), .out(out_a));
  br_enc_priority_encoder #(.NumRequesters(4), .NumResults(2)) u_dut_b (
    .clk(clk), .rst(rst_n), .in(in_b), .out(out_b));
  br_enc_priority_encoder #(.NumRequesters(4), .NumResults(4)) u_dut_c (
    .clk(clk), .rst(rst_n), .in(in_c), .out(out_c));
  br_enc_priority_encoder #(.NumRequesters(8), .NumResults(3)) u_dut_d (
    .clk(clk), .rst(rst_n), .in(in_d), .out(out_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scan upward, granting each set bit until three grants are given.
  function automatic logic [23:0] ref_d(input logic [7:0] v);
    logic [23:0] r;
    int cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && cnt < 3) begin
        r[cnt*8 + i] = 1'b1;
        cnt++;
      end
    end
    return r;
  endfunction

  initial begin
    logic [3:0] r_one;
    logic [3:0] r_trunc;
    r_one   = 4'b0001;
    r_trunc = 4'b1010;

    // Output follows input even while reset is held.
    in_a = 2'b01; #2;
    check("a_in_reset_01", 32'(out_a), 32'h1);
    in_a = 2'b10; #2;
    check("a_in_reset_10", 32'(out_a), 32'h2);
    rst_n = 1'b1; #2;

    in_a = 2'b00; #2; check("a_00", 32'(out_a), 32'h0);
    in_a = 2'b01; #2; check("a_01", 32'(out_a), 32'h1);
    in_a = 2'b10; #2; check("a_10", 32'(out_a), 32'h2);
    in_a = 2'b11; #2; check("a_11", 32'(out_a), 32'h1);
    in_a = r_trunc[1:0]; #2; check("a_trunc_1010", 32'(out_a), 32'h2);

    in_b = 4'b1010; #2; check("b_1010", 32'(out_b), 32'h82);
    in_b = 4'b1111; #2; check("b_1111", 32'(out_b), 32'h21);
    in_b = 4'b0000; #2; check("b_0000", 32'(out_b), 32'h00);
    for (int i = 0; i < 4; i++) begin
      in_b = r_one << i; #2;
      check($sformatf("b_walk_%0d", i), 32'(out_b), {24'h0, 4'h0, r_one << i});
    end

    in_c = 4'b0110; #2; check("c_0110", 32'(out_c), 32'h0042);
    in_c = 4'b0000; #2; check("c_0000", 32'(out_c), 32'h0000);
    in_c = 4'b1111; #2; check("c_1111", 32'(out_c), 32'h8421);
    in_c = 4'b1000; #2; check("c_1000", 32'(out_c), 32'h0008);

    in_d = 8'h00; #2; check("d_zero", 32'(out_d), 32'h000000);
    in_d = 8'hFF; #2; check("d_ones", 32'(out_d), 32'h040201);
    in_d = 8'h81; #2; check("d_81",   32'(out_d), 32'h008001);
    in_d = 8'hF0; #2; check("d_f0",   32'(out_d), 32'h402010);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) rst_n = 1'b0;
      if (i == 600) rst_n = 1'b1;
      in_d = 8'($urandom_range(0, 255)); #2;
      check($sformatf("d_rand_%0d_in_%h", i, in_d), 32'(out_d), 32'(ref_d(in_d)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/br_enc_priority_encoder.md
Name: br_enc_priority_encoder

Overview:
Combinational multi-result priority encoder. It takes a request vector and produces up to NumResults one-hot grant vectors. Result 0 selects the lowest-index set request, result 1 the next-lowest, and so on. It is used inside arbiters and allocators as a zero-latency find-first-N-set primitive. The clock and reset are used only by integration/implementation assertions; the datapath has no state.

Parameters:
NumRequesters, 2, width of request vector; legal range >= 2.
NumResults, 1, number of one-hot results produced; legal range 1..NumRequesters.

Ports:
clk  input  1  clock; used only for assertion sampling.
rst  input  1  reset; asynchronous, active-low. Assertions are disabled while asserted (rst=0).
in  input  NumRequesters  request vector; bit 0 is highest priority.
out  output  NumResults x NumRequesters (packed [NumResults-1:0][NumRequesters-1:0])  out[k] is a one-hot grant for the (k+1)-th lowest-index set bit of in, or all-zero if none exists.

Behaviour:
- Purely combinational: out is a function of in only, with zero-cycle latency. There are no flops.
- Reset has no effect on out, and there is no reset value; out tracks in during reset as well.
- out[0] = in & ~(in - 1), i.e. the lowest set bit. If in == 0, out[0] = 0.
- Masking chain: m0 = in; m(k+1) = m(k) & ~out[k]; out[k] = lowest set bit of m(k).
- Count rule: with popcount(in) = p, out[k] is nonzero exactly for k < min(p, NumResults); the remaining results are 0.
- Bits of in beyond NumResults set bits are ignored. There is no "overflow" indication.
- Invariants, which must hold always:
  - each out[k] is onehot0;
  - out[k] is a subset of in;
  - out[j] & out[k] == 0 for j != k;
  - out[k] != 0 implies out[k-1] != 0;
  - the index of out[k] is strictly greater than the index of out[k-1] when both are nonzero.
- Boundary cases:
  - in = all-zero gives all outputs zero.
  - in = all-ones gives out[k] = 1 << k for every k.
  - NumResults = NumRequesters with all-ones input gives every output nonzero.
- Elaboration checks: static assertions reject NumRequesters < 2, NumResults < 1, and NumResults > NumRequesters.
- Integration assertion: in has no X/Z when rst is deasserted (sampled at posedge clk).
- Implementation assertions: the invariants above, sampled at posedge clk and disabled while rst = 0.
- Implementation style:
  - a generate loop over results, each a masked find-first-set;
  - a prefix-OR based lowest-bit extraction is acceptable;
  - no arithmetic on widths beyond NumRequesters.

Decomposition:
- No shared package is needed: there are no typedefs or enums, and the constants are local to the module.
- One natural sub-module is br_enc_find_first_set: a single-result lowest-set-bit one-hot extractor, parameterised by Width.
- It is instantiated NumResults times in the masking chain.
- The assertion macros come from the team's standard assertion include files.

Test Plan:
- Default config (2,1): drive in=2'b00, 2'b01, 2'b10, 2'b11 -> out[0] = 00, 01, 10, 01 respectively, valid in the same cycle.
- Default config, in = truncated 4'b1010 (= 2'b10) -> out[0] = 2'b10 (lower index masked, higher not present).
- Config (4,2): in=4'b1010 -> out[0]=4'b0010, out[1]=4'b1000. in=4'b1111 -> out[0]=0001, out[1]=0010.
- Config (4,2), walking one-hot: in = 1<<i for i = 0..3 -> out[0] = 1<<i, out[1] = 0 every step.
- Config (4,4): in=4'b0110 -> out = {0000, 0000, 0100, 0010} (out[3..0]). in=0 -> all zero.
- Random sweep (8,3), 1000 random vectors -> out matches the reference model (k-th lowest set bit); invariants hold; toggling rst mid-sweep does not change out.
